// File: rtl/spi_cfg_sequencer_pkg.sv
// Shared types and constants for the config-register SPI write sequencer.
package spi_cfg_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam logic        WRITE_BIT  = 1'b1;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned REQ_W      = ADDR_W + DATA_W;

  localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] REG_PWM_CTRL    = 7'h02;
  localparam logic [ADDR_W-1:0] REG_PWM_PERIOD  = 7'h03;
  localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Write frame as it appears on the wire, MSB first.
  function automatic logic [FRAME_BITS-1:0] build_frame(input req_t r);
    return {WRITE_BIT, r.addr, r.data};
  endfunction

endpackage

// File: rtl/spi_cfg_sequencer_if.sv
// Local write-request handshake into the SPI config sequencer.
interface spi_cfg_req_if;
  import spi_cfg_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;

  modport master (output req_valid, req_addr, req_data, input req_ready);
  modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/spi_cfg_sequencer_fifo.sv
// Synchronous request FIFO; full/empty are flops derived from the next pointers.
module spi_cfg_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push, do_pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    do_push  = push && !full_q;
    do_pop   = pop && !empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    // Extra MSB distinguishes full from empty when the index bits match.
    empty_d = (wr_ptr_d == rd_ptr_d);
    full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata_c = mem_q[rd_ptr_q[AW-1:0]];
  assign full    = full_q;
  assign empty   = empty_q;

endmodule

// File: rtl/spi_cfg_sequencer.sv
// Queues register writes and serialises each as a 16-bit SPI mode-0 write frame.
module spi_cfg_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned HALF_DIV   = 4,
  parameter int unsigned CS_SETUP   = 4,
  parameter int unsigned CS_HOLD    = 4,
  parameter int unsigned CS_GAP     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  spi_cfg_req_if.slave req,
  output logic         ncs,
  output logic         sclk,
  output logic         copi,
  output logic         busy,
  output logic         frame_done
);
  localparam int unsigned PH_MAX = max_u(max_u(HALF_DIV, CS_SETUP), max_u(CS_HOLD, CS_GAP));
  localparam int unsigned PH_W   = $clog2(PH_MAX);
  localparam int unsigned BIT_W  = $clog2(FRAME_BITS);

  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_BITS - 1);
  localparam logic [PH_W-1:0]  HALF_END  = PH_W'(HALF_DIV - 1);
  localparam logic [PH_W-1:0]  SETUP_END = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0]  HOLD_END  = PH_W'(CS_HOLD - 1);
  localparam logic [PH_W-1:0]  GAP_END   = PH_W'(CS_GAP - 1);

  state_e                state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  ncs_q, ncs_d, sclk_q, sclk_d;
  logic                  busy_q, busy_d, frame_done_q, frame_done_d;

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REQ_W-1:0] fifo_wdata, fifo_rdata;

  assign req.req_ready = !fifo_full;
  assign fifo_push     = req.req_valid && !fifo_full;
  assign fifo_wdata    = {req.req_addr, req.req_data};

  spi_cfg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .wdata   (fifo_wdata),
    .rdata_c (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Frame sequencing; copi is the shift register MSB, so clearing it idles copi low.
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q + PH_W'(1);
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    ncs_d        = ncs_q;
    sclk_d       = sclk_q;
    frame_done_d = 1'b0;
    fifo_pop     = 1'b0;
    busy_d       = (state_q != ST_IDLE) || !fifo_empty;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shreg_d  = build_frame(req_t'(fifo_rdata));
          ncs_d    = 1'b0;
          bit_d    = '0;
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (phase_q == SETUP_END) begin
          phase_d = '0;
          sclk_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (phase_q == HALF_END) begin
          phase_d = '0;
          if (sclk_q) begin
            sclk_d = 1'b0;
            if (bit_q != LAST_BIT) shreg_d = {shreg_q[FRAME_BITS-2:0], 1'b0};
          end else if (bit_q == LAST_BIT) begin
            state_d = ST_HOLD;
          end else begin
            sclk_d = 1'b1;
            bit_d  = bit_q + BIT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (phase_q == HOLD_END) begin
          phase_d      = '0;
          ncs_d        = 1'b1;
          frame_done_d = 1'b1;
          shreg_d      = '0;
          state_d      = ST_GAP;
        end
      end
      ST_GAP: begin
        if (phase_q == GAP_END) begin
          phase_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        phase_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      ncs_q        <= 1'b1;
      sclk_q       <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      ncs_q        <= ncs_d;
      sclk_q       <= sclk_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ncs        = ncs_q;
  assign sclk       = sclk_q;
  assign copi       = shreg_q[FRAME_BITS-1];
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_cfg_sequencer.sv
// Bench for spi_cfg_sequencer: timeline-based reference model, wire-level frame decoder, directed + random stimulus.
module tb_spi_cfg_sequencer;
  localparam int DEPTH = 4;
  localparam int HD    = 4;
  localparam int SU    = 4;
  localparam int HO    = 4;
  localparam int GP    = 8;
  localparam int FLEN  = SU + 32*HD + HO;
  localparam int FEND  = FLEN + GP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ncs, sclk, copi, busy, frame_done;

  spi_cfg_req_if bus();

  spi_cfg_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .HALF_DIV   (HD),
    .CS_SETUP   (SU),
    .CS_HOLD    (HO),
    .CS_GAP     (GP)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (bus),
    .ncs        (ncs),
    .sclk       (sclk),
    .copi       (copi),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each frame is a fixed timeline counted from the pop edge.
  logic [14:0] mq[$];
  logic [15:0] sent_q[$];
  bit          m_active = 1'b0;
  int          m_pos = 0;
  logic [15:0] m_word = '0;
  bit          m_ready = 1'b1;
  bit          m_busy = 1'b0;
  bit          m_fd = 1'b0;
  bit          old_active, m_push;
  int          old_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      sent_q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ready  = 1'b1;
      m_busy   = 1'b0;
      m_fd     = 1'b0;
    end else begin
      old_active = m_active;
      old_n      = mq.size();
      m_push     = bus.req_valid && m_ready;
      m_busy     = old_active || (old_n != 0);
      m_fd       = 1'b0;
      if (old_active) begin
        m_pos++;
        if (m_pos == FLEN) m_fd = 1'b1;
        if (m_pos == FEND) m_active = 1'b0;
      end else if (old_n != 0) begin
        m_word   = {1'b1, mq.pop_front()};
        sent_q.push_back(m_word);
        m_active = 1'b1;
        m_pos    = 0;
      end
      if (m_push) mq.push_back({bus.req_addr, bus.req_data});
      m_ready = (mq.size() < DEPTH);
    end
  end

  function automatic void exp_pins(output bit e_ncs, output bit e_sclk, output bit e_copi);
    int rel, n;
    e_ncs = 1'b1; e_sclk = 1'b0; e_copi = 1'b0;
    if (m_active && m_pos < FLEN) begin
      e_ncs  = 1'b0;
      rel    = m_pos - SU;
      e_sclk = (rel >= 0) && (rel < 32*HD) && ((rel % (2*HD)) < HD);
      n      = (rel < 0) ? 0 : (rel + HD) / (2*HD);
      if (n > 15) n = 15;
      e_copi = m_word[15-n];
    end
  endfunction

  // Per-cycle compare plus wire-level decoding of frames into a register map.
  logic [7:0]  regs [5];
  logic        prev_sclk = 1'b0, prev_ncs = 1'b1;
  logic [15:0] dec_sr = '0, last_dec = '0;
  int dec_bits = 0, low_cnt = 0, last_low = 0, gap_cnt = 0, min_gap = 1000000;
  int n_frames = 0, partial_cnt = 0, fd_cnt = 0;
  bit seen_frame = 1'b0;
  bit e_ncs, e_sclk, e_copi;

  initial for (int i = 0; i < 5; i++) regs[i] = 8'h00;

  always @(negedge clk) begin
    exp_pins(e_ncs, e_sclk, e_copi);
    chk("ncs", ncs, e_ncs);
    chk("sclk", sclk, e_sclk);
    chk("copi", copi, e_copi);
    chk("busy", busy, m_busy);
    chk("frame_done", frame_done, m_fd);
    chk("req_ready", bus.req_ready, m_ready);

    if (sclk && !prev_sclk) begin
      dec_sr = {dec_sr[14:0], copi};
      dec_bits++;
    end
    if (!ncs && prev_ncs && seen_frame && gap_cnt < min_gap) min_gap = gap_cnt;
    if (ncs && !prev_ncs) begin
      if (dec_bits == 16) begin
        last_dec = dec_sr;
        n_frames++;
        if (sent_q.size() == 0) chk("frame_unexpected", dec_sr, 16'h0);
        else chk("frame", dec_sr, sent_q.pop_front());
        if (dec_sr[15] && dec_sr[14:8] < 7'd5) regs[int'(dec_sr[14:8])] = dec_sr[7:0];
      end else begin
        partial_cnt++;
      end
      dec_bits   = 0;
      last_low   = low_cnt;
      low_cnt    = 0;
      gap_cnt    = 0;
      seen_frame = 1'b1;
    end
    if (!ncs) low_cnt++;
    else      gap_cnt++;
    if (frame_done) fd_cnt++;
    prev_sclk = sclk;
    prev_ncs  = ncs;
  end

  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic push(input logic [6:0] a, input logic [7:0] d);
    int  guard;
    bit  r;
    guard = 0;
    bus.req_valid = 1'b1;
    bus.req_addr  = a;
    bus.req_data  = d;
    forever begin
      r = bus.req_ready;
      cyc();
      if (r) break;
      guard++;
      if (guard > 5000) begin
        chk("push_timeout", 32'(guard), 32'd0);
        break;
      end
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    repeat (2) cyc();
    while (busy !== 1'b0 && n < budget) begin
      cyc();
      n++;
    end
    if (n >= budget) chk("idle_timeout", 32'(n), 32'(budget - 1));
  endtask

  int fd0, fr0, cnt;

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    repeat (3) cyc();
    chk("rst_ncs", ncs, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_copi", copi, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", bus.req_ready, 1'b1);
    rst_n = 1'b1;
    repeat (2) cyc();

    // Single write
    fd0 = fd_cnt;
    push(7'h00, 8'hA5);
    wait_idle(1000);
    chk("t1_frame", last_dec, 16'h80A5);
    chk("t1_ncs_low", 32'(last_low), 32'd136);
    chk("t1_frame_done", 32'(fd_cnt - fd0), 32'd1);
    chk("t1_reg0", regs[0], 8'hA5);

    // Five back-to-back writes; queue fills behind the first frame
    push(7'h00, 8'h11);
    push(7'h01, 8'h22);
    push(7'h02, 8'h33);
    push(7'h03, 8'h44);
    push(7'h04, 8'h80);
    chk("t2_ready_full", bus.req_ready, 1'b0);
    wait_idle(3000);
    chk("t2_reg0", regs[0], 8'h11);
    chk("t2_reg1", regs[1], 8'h22);
    chk("t2_reg2", regs[2], 8'h33);
    chk("t2_reg3", regs[3], 8'h44);
    chk("t2_reg4", regs[4], 8'h80);
    chk("t2_gap_ok", 32'(min_gap >= GP), 32'd1);

    // Undefined address goes out unchanged
    push(7'h05, 8'hFF);
    wait_idle(1000);
    chk("t3_frame", last_dec, 16'h85FF);
    chk("t3_reg0", regs[0], 8'h11);
    chk("t3_reg4", regs[4], 8'h80);

    // Reset during bit 7 of a frame
    push(7'h01, 8'h5A);
    cnt = 0;
    while (dec_bits < 8 && cnt < 1000) begin
      cyc();
      cnt++;
    end
    chk("t4_reached_bit7", 32'(dec_bits), 32'd8);
    rst_n = 1'b0;
    #1;
    chk("t4_ncs_now", ncs, 1'b1);
    chk("t4_sclk_now", sclk, 1'b0);
    chk("t4_ready_now", bus.req_ready, 1'b1);
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    chk("t4_busy", busy, 1'b0);
    chk("t4_partial", 32'(partial_cnt), 32'd1);
    chk("t4_reg1_kept", regs[1], 8'h22);
    push(7'h02, 8'h3C);
    wait_idle(1000);
    chk("t4_clean_frame", last_dec, 16'h823C);
    chk("t4_reg2", regs[2], 8'h3C);

    // Full FIFO: further push waits for a pop
    fr0 = n_frames;
    for (int i = 0; i < 6; i++) push(7'(8'h10 + i), 8'($urandom_range(0, 255)));
    wait_idle(3000);
    chk("t5_frames", 32'(n_frames - fr0), 32'd6);

    // Randomised traffic
    fr0 = n_frames;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 200)) cyc();
      push(7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
    end
    wait_idle(10000);
    chk("rnd_frames", 32'(n_frames - fr0), 32'd40);
    chk("rnd_drained", 32'(sent_q.size()), 32'd0);

    // Idle period
    fd0 = fd_cnt;
    repeat (1000) cyc();
    chk("idle_frame_done", 32'(fd_cnt - fd0), 32'd0);
    chk("idle_ncs", ncs, 1'b1);
    chk("idle_sclk", sclk, 1'b0);
    chk("idle_busy", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
